// File: rtl/lcd_fb_scanout.sv
// lcd_fb_scanout: reads a COLS x ROWS framebuffer from a 1-cycle-latency BRAM port
// in address order, then streams the pixels over valid/ready with start-of-frame and
// end-of-line tags.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         synchronous active-high reset
//   start_i       frame request, honoured only while idle
//   fb_addr_o     framebuffer read address
//   fb_we_o       framebuffer write enable (always 0)
//   fb_din_o      framebuffer write data (always 0)
//   fb_dout_i     framebuffer read data, mem[fb_addr_o] one cycle later
//   fb_busy_o     high while a frame is being scanned; writers must hold off
//   px_data_o     pixel value (FIFO head)
//   px_sof_o      pixel is address 0
//   px_eol_o      pixel is the last column of its line
//   px_valid_o    pixel valid
//   px_ready_i    sink ready
//   frame_done_o  1-cycle pulse after the last pixel of a frame is accepted
module lcd_fb_scanout #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned COLS       = 160,
  parameter int unsigned ROWS       = 80,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned CONTINUOUS = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] fb_addr_o,
  output logic              fb_we_o,
  output logic [WIDTH-1:0]  fb_din_o,
  input  logic [WIDTH-1:0]  fb_dout_i,
  output logic              fb_busy_o,
  output logic [WIDTH-1:0]  px_data_o,
  output logic              px_sof_o,
  output logic              px_eol_o,
  output logic              px_valid_o,
  input  logic              px_ready_i,
  output logic              frame_done_o
);

  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic              inflight_q;
  logic              cap_sof_q, cap_eol_q;
  logic              done_q, done_d;

  // Two-entry FIFO holding pixel data with its tags.
  logic [WIDTH-1:0]  fifo_data_q [2];
  logic              fifo_sof_q  [2];
  logic              fifo_eol_q  [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;

  logic push, pop, issue, credit_ok, col_last, is_last;

  assign push     = inflight_q;
  assign pop      = (count_q != 2'd0) && px_ready_i;
  assign col_last = (col_q == ColW'(COLS - 1));
  assign is_last  = col_last && (row_q == RowW'(ROWS - 1));

  // Credit rule: count + inflight - pop < 2, rearranged to avoid underflow.
  assign credit_ok = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
  assign issue     = (state_q == StRun) && credit_ok;
  assign count_d   = count_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StRun;
      end
      StRun: begin
        if (issue) begin
          if (is_last) begin
            // Rewind now so a continuous restart can issue address 0 immediately.
            state_d = StDrain;
            addr_d  = '0;
            col_d   = '0;
            row_d   = '0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (col_last) begin
              col_d = '0;
              row_d = row_q + RowW'(1);
            end else begin
              col_d = col_q + ColW'(1);
            end
          end
        end
      end
      StDrain: begin
        // No reads issue here, so an empty FIFO after this edge means the last pixel popped.
        if (count_d == 2'd0) begin
          done_d  = 1'b1;
          state_d = (CONTINUOUS != 0) ? StRun : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      inflight_q <= 1'b0;
      cap_sof_q  <= 1'b0;
      cap_eol_q  <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_sof_q[i]  <= 1'b0;
        fifo_eol_q[i]  <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      inflight_q <= issue;
      done_q     <= done_d;
      count_q    <= count_d;
      if (issue) begin
        cap_sof_q <= (addr_q == '0);
        cap_eol_q <= col_last;
      end
      if (push) begin
        fifo_data_q[wr_ptr_q] <= fb_dout_i;
        fifo_sof_q[wr_ptr_q]  <= cap_sof_q;
        fifo_eol_q[wr_ptr_q]  <= cap_eol_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign fb_addr_o    = addr_q;
  assign fb_we_o      = 1'b0;
  assign fb_din_o     = '0;
  assign fb_busy_o    = (state_q != StIdle);
  assign px_valid_o   = (count_q != 2'd0);
  assign px_data_o    = fifo_data_q[rd_ptr_q];
  assign px_sof_o     = fifo_sof_q[rd_ptr_q];
  assign px_eol_o     = fifo_eol_q[rd_ptr_q];
  assign frame_done_o = done_q;

endmodule
